clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, counter and config width in bits (range 2..32).
REQ-002 SHALL have parameter DIV_RST, default 100, divide ratio loaded at reset.
REQ-003 SHALL have parameter HIGH_RST, default 50, high time in clk cycles loaded at reset.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  in  1  run enable; low holds the generator idle.
REQ-007 SHALL have port cfg_valid  in  1  new configuration offered.
REQ-008 SHALL have port cfg_div  in  CNT_W  requested period in clk cycles.
REQ-009 SHALL have port cfg_high  in  CNT_W  requested high time in clk cycles.
REQ-010 SHALL have port cfg_ready  out  1  configuration can be accepted.
REQ-011 SHALL have port cfg_err  out  1  one-cycle pulse: offered configuration rejected.
REQ-012 SHALL have port clk_out  out  1  divided clock, registered.
REQ-013 SHALL have port tick  out  1  one-cycle pulse at the start of each period, registered.

Function
REQ-014 SHALL keep active registers div_cur and high_cur, plus a pending register set (div_pend, high_pend, pend flag).
REQ-015 SHALL implement states IDLE (en=0), RUN (en=1, no pending), RUN_PEND (en=1, pend=1).
REQ-016 In IDLE: cnt=0, clk_out=0, tick=0; on en=1 -> RUN, and cnt counts from 0 on the next cycle.
REQ-017 In RUN/RUN_PEND: cnt increments by 1 each cycle; when cnt = div_cur-1 it wraps to 0.
REQ-018 clk_out SHALL equal the previous cycle's (cnt < high_cur) while en=1; latency of 1 cycle from cnt.
REQ-019 tick SHALL be 1 in the cycle after cnt=0 while enabled; exactly one tick per period of div_cur cycles.
REQ-020 high_cur=0 -> clk_out constant 0; high_cur >= div_cur -> clk_out constant 1; ticks continue in both cases.
REQ-021 cfg_ready SHALL be 1 when pend=0 and not in reset; handshake fires when cfg_valid & cfg_ready.
REQ-022 Handshake with cfg_div < 2: configuration discarded, cfg_err=1 next cycle, pend unchanged.
REQ-023 Valid handshake: pending set loaded, pend=1, cfg_ready=0 from next cycle.
REQ-024 In RUN_PEND, pending set SHALL transfer to active at the wrap (cnt = div_cur-1 -> 0); new period begins with new values; pend clears, cfg_ready=1 next cycle.
REQ-025 Valid handshake while in IDLE SHALL load div_cur/high_cur directly (no pend), cfg_ready stays 1.
REQ-026 en falling while pend=1: pending set applied immediately, pend cleared, state -> IDLE.
REQ-027 en=0 in any cycle: next cycle cnt=0, clk_out=0; no partial period resumed.
REQ-028 No glitch: clk_out SHALL change only on clk rising edge and never toggle mid-period except at the high_cur boundary.
REQ-029 Counter arithmetic SHALL be CNT_W bits unsigned; cfg_div up to 2^CNT_W-1 supported without overflow.

Reset
REQ-030 rst=1 at a clk edge: cnt=0, div_cur=DIV_RST, high_cur=HIGH_RST, pend=0, clk_out=0, tick=0, cfg_err=0, state IDLE.
REQ-031 cfg_ready SHALL be 0 during rst=1 and 1 in the first cycle after rst deasserts.
REQ-032 rst SHALL override en and cfg_valid; a handshake in a reset cycle is ignored.
REQ-033 Reset mid-period or with pending config SHALL discard pending set and restore reset values.

Verification
REQ-034 Defaults: rst 2 cycles, en=1 -> clk_out period 100 cycles, high 50, tick every 100 cycles.
REQ-035 Runtime reload: in RUN, offer div=10 high=3 at cnt=20 -> cfg_ready=0 until wrap; old 100/50 period completes, then 10-cycle periods with high 3; cfg_ready=1 one cycle after wrap.
REQ-036 Reject: offer div=1 -> cfg_err pulse 1 cycle, output unchanged 100/50; div=2 high=1 accepted -> clk_out toggles every cycle.
REQ-037 Extremes: high=0 -> clk_out stays 0; high=10 with div=10 -> clk_out stays 1; tick every 10 cycles both.
REQ-038 en drop with pending div=8: en=0 -> next cycle clk_out=0, cnt=0; en=1 -> 8-cycle periods immediately.
REQ-039 Reset mid-operation at cnt=37 with pending config -> all outputs reset values, pending discarded, defaults 100/50 resume on en.

Source files
------------

// File: rtl/clk_div_gen.sv
// Programmable clock divider: registered divided clock plus period-start tick,
// with a one-deep pending configuration that takes effect at the period wrap.
module clk_div_gen #(
    parameter int CNT_W    = 16,
    parameter int DIV_RST  = 100,
    parameter int HIGH_RST = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        RUN_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST_V  = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] HIGH_RST_V = CNT_W'(HIGH_RST);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] high_cur_q, high_cur_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic [CNT_W-1:0] high_pend_q, high_pend_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;

    logic             hs;
    logic             cfg_bad;
    logic             cfg_good;

    assign cfg_ready = ~pend_q & ~rst;
    assign hs        = cfg_valid & cfg_ready;
    assign cfg_bad   = (cfg_div < TWO);
    assign cfg_good  = hs & ~cfg_bad;

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_cur_d   = div_cur_q;
        high_cur_d  = high_cur_q;
        div_pend_d  = div_pend_q;
        high_pend_d = high_pend_q;
        pend_d      = pend_q;
        clk_out_d   = 1'b0;
        tick_d      = 1'b0;
        cfg_err_d   = hs & cfg_bad;

        if (!en) begin
            // Dropping enable abandons the period; any pending set becomes active now.
            cnt_d   = '0;
            state_d = IDLE;
            if (pend_q) begin
                div_cur_d  = div_pend_q;
                high_cur_d = high_pend_q;
                pend_d     = 1'b0;
            end
            if (cfg_good) begin
                div_cur_d  = cfg_div;
                high_cur_d = cfg_high;
            end
        end else if (state_q == IDLE) begin
            cnt_d   = '0;
            state_d = RUN;
            if (cfg_good) begin
                div_cur_d  = cfg_div;
                high_cur_d = cfg_high;
            end
        end else begin
            clk_out_d = (cnt_q < high_cur_q);
            tick_d    = (cnt_q == '0);
            if (cnt_q >= div_cur_q - ONE) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_cur_d  = div_pend_q;
                    high_cur_d = high_pend_q;
                    pend_d     = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
            // Handshake only fires with pend_q low, so it never collides with the transfer above.
            if (cfg_good) begin
                div_pend_d  = cfg_div;
                high_pend_d = cfg_high;
                pend_d      = 1'b1;
            end
            state_d = pend_d ? RUN_PEND : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_cur_q   <= DIV_RST_V;
            high_cur_q  <= HIGH_RST_V;
            div_pend_q  <= '0;
            high_pend_q <= '0;
            pend_q      <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_cur_q   <= div_cur_d;
            high_cur_q  <= high_cur_d;
            div_pend_q  <= div_pend_d;
            high_pend_q <= high_pend_d;
            pend_q      <= pend_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios then random traffic, every cycle
// compared against a period-position reference model.
module tb_clk_div_gen;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_high;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: position within the current period (-1 = idle).
    int m_div, m_high, m_pdiv, m_phigh, m_pos;
    bit m_pend, e_clk, e_tick, e_err;

    clk_div_gen #(.CNT_W(W), .DIV_RST(100), .HIGH_RST(50)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: observed no finish, expected finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit hs, good;
        if (rst) begin
            m_div = 100; m_high = 50; m_pend = 0; m_pos = -1;
            e_clk = 0; e_tick = 0; e_err = 0;
            return;
        end
        hs    = cfg_valid && !m_pend;
        good  = hs && (int'(cfg_div) >= 2);
        e_err = hs && (int'(cfg_div) < 2);
        e_clk = 0;
        e_tick = 0;
        if (!en) begin
            if (m_pend) begin m_div = m_pdiv; m_high = m_phigh; m_pend = 0; end
            if (good) begin m_div = int'(cfg_div); m_high = int'(cfg_high); end
            m_pos = -1;
        end else if (m_pos < 0) begin
            if (good) begin m_div = int'(cfg_div); m_high = int'(cfg_high); end
            m_pos = 0;
        end else begin
            e_clk  = (m_pos < m_high);
            e_tick = (m_pos == 0);
            m_pos++;
            if (m_pos == m_div) begin
                m_pos = 0;
                if (m_pend) begin m_div = m_pdiv; m_high = m_phigh; m_pend = 0; end
            end
            if (good) begin m_pdiv = int'(cfg_div); m_phigh = int'(cfg_high); m_pend = 1; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("clk_out", clk_out, e_clk);
        chk("tick", tick, e_tick);
        chk("cfg_err", cfg_err, e_err);
        chk("cfg_ready", cfg_ready, !m_pend && !rst);
    endtask

    // Measure one full period starting at the next tick: spacing and high time.
    task automatic measure(input int exp_per, input int exp_high, input string tag);
        int n, hc, per;
        n = 0;
        while (!tick && n < 300) begin step(); n++; end
        chk({tag, "_tick_seen"}, tick, 1'b1);
        hc = 0; per = 0;
        do begin
            hc += int'(clk_out);
            step();
            per++;
        end while (!tick && per < 300);
        chk_int({tag, "_period"}, per, exp_per);
        chk_int({tag, "_high"}, hc, exp_high);
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 400) begin step(); n++; end
        chk("wait_pos", m_pos == p, 1'b1);
    endtask

    task automatic offer_and_settle(input int d, input int h);
        int n;
        cfg_valid = 1'b1; cfg_div = W'(d); cfg_high = W'(h);
        step();
        cfg_valid = 1'b0;
        n = 0;
        while (m_pend && n < 400) begin step(); n++; end
        chk("pend_settled", cfg_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
        // Reset, with a handshake offered that must be ignored
        step();
        cfg_valid = 1'b1; cfg_div = W'(5); cfg_high = W'(2);
        step();
        cfg_valid = 1'b0;
        rst = 1'b0;
        step();
        en = 1'b1;
        measure(100, 50, "default");

        // Runtime reload at cnt=20
        wait_pos(20);
        cfg_valid = 1'b1; cfg_div = W'(10); cfg_high = W'(3);
        step();
        cfg_valid = 1'b0;
        step();
        chk("reload_ready_low", cfg_ready, 1'b0);
        measure(10, 3, "reload");

        // Reject div=1
        cfg_valid = 1'b1; cfg_div = W'(1); cfg_high = W'(0);
        step();
        chk("reject_err", cfg_err, 1'b1);
        cfg_valid = 1'b0;
        step();
        chk("reject_err_clear", cfg_err, 1'b0);
        measure(10, 3, "after_reject");

        // Minimum divide
        offer_and_settle(2, 1);
        measure(2, 1, "div2");
        measure(2, 1, "div2b");

        // Extremes
        offer_and_settle(10, 0);
        measure(10, 0, "high0");
        offer_and_settle(10, 10);
        measure(10, 10, "highfull");

        // Enable drop with pending div=8
        wait_pos(4);
        cfg_valid = 1'b1; cfg_div = W'(8); cfg_high = W'(4);
        step();
        cfg_valid = 1'b0;
        en = 1'b0;
        step();
        chk("endrop_clk", clk_out, 1'b0);
        chk("endrop_ready", cfg_ready, 1'b1);
        en = 1'b1;
        measure(8, 4, "endrop");

        // Reset mid-period with a pending config
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_pos(10);
        cfg_valid = 1'b1; cfg_div = W'(20); cfg_high = W'(5);
        step();
        cfg_valid = 1'b0;
        wait_pos(37);
        rst = 1'b1;
        step();
        chk("midrst_ready", cfg_ready, 1'b0);
        rst = 1'b0;
        step();
        chk("midrst_ready_after", cfg_ready, 1'b1);
        measure(100, 50, "after_rst");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 24) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_div   = W'($urandom_range(0, 20));
            cfg_high  = W'($urandom_range(0, 22));
            step();
        end
        rst = 1'b0; cfg_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
